mmio_bridge: RTL and testbench
==============================

Name: mmio_bridge

Overview:
- Sits between the single-cycle/multicycle CPU data port and two targets: the data memory and the PDU IO bus (io_addr/io_dout/io_we/io_rd/io_din).
- Decodes each CPU access by address region and runs it as a registered bus transaction.
- Guarantees exactly one io_rd/io_we pulse per access, which the PDU's read-clears-valid logic (swx_data at 0x14) depends on.
- Returns read data and a one-cycle acknowledge to the CPU.

Parameters:
- IO_BASE, 32'hFFFF_FF00: base of the 256-byte IO region. An access is IO when cpu_addr[31:8] == IO_BASE[31:8].
- MEM_AW, 8: data-memory word-address width. mem_addr = cpu_addr[MEM_AW+1:2].

Ports:
- clk  in  1  clock (clk_cpu domain)
- rstn  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  32  byte address; stable while cpu_req is high
- cpu_wdata  in  32  write data; stable while cpu_req is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data; valid in the cpu_ack cycle and held afterwards
- mem_addr  out  MEM_AW  data-memory word address
- mem_wdata  out  32  data-memory write data
- mem_we  out  1  data-memory write enable
- mem_re  out  1  data-memory read enable
- mem_rdata  in  32  data-memory read data; synchronous, valid 1 cycle after mem_re
- io_addr  out  8  IO register offset, cpu_addr[7:0]
- io_dout  out  32  IO write data
- io_we  out  1  IO write strobe
- io_rd  out  1  IO read strobe
- io_din  in  32  IO read data from the PDU; combinational on io_addr
- err  out  1  sticky misaligned-access flag
- err_addr  out  32  address of the first misaligned access

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE.
  - cpu_ack = mem_we = mem_re = io_we = io_rd = err = 0.
  - cpu_rdata, mem_addr, mem_wdata, io_addr, io_dout, err_addr = 0.
  - Reset mid-transaction aborts it: no ack, no strobe in the cycle after release.
- Every output is registered.
- States: IDLE, IOW, IOR, MWR, MRD, MCAP, ACK.
- IDLE with cpu_req=1 latches addr/wdata into the target-side output registers, then branches:
  - cpu_addr[1:0] != 0 -> ACK. No bus strobe. cpu_rdata <= 0. If err==0: err <= 1 and err_addr <= cpu_addr.
  - IO write -> IOW. io_we = 1 for exactly that cycle; io_addr and io_dout valid. Next state ACK.
  - IO read -> IOR. io_rd = 1 for exactly that cycle. io_din is sampled into cpu_rdata at the end of IOR. Next state ACK.
  - Memory write -> MWR. mem_we = 1 for one cycle. Next state ACK.
  - Memory read -> MRD. mem_re = 1 for one cycle. Next state MCAP, where cpu_rdata <= mem_rdata. Next state ACK.
- ACK:
  - cpu_ack = 1 for one cycle; always returns to IDLE.
  - cpu_req is ignored during ACK, so a held request is not re-issued in the same cycle.
  - A request still high in the following IDLE cycle is a new access.
- Latency, counted in cycles from the IDLE cycle that samples cpu_req to cpu_ack:
  - IO write: 2
  - IO read: 2
  - memory write: 2
  - memory read: 3
  - misaligned access: 1
- Outside strobe cycles, io_addr/io_dout and mem_addr/mem_wdata hold their last values; strobes are 0.
- cpu_rdata changes only on a read completion (or misaligned access). Writes leave it unchanged.
- Strobe exclusivity: at most one of io_we, io_rd, mem_we, mem_re is high in any cycle.
- Region boundary:
  - 0xFFFF_FEFC is memory (mem_addr is the truncated word address).
  - 0xFFFF_FF00 is IO with io_addr = 0x00.
  - 0xFFFF_FFFC is IO with io_addr = 0xFC.
- Memory addresses wrap modulo 2^MEM_AW words; there is no range error.
- err is cleared only by reset. A second misaligned access does not overwrite err_addr.

Test Plan:
- Reset, then IO write: cpu_addr=0xFFFF_FF0C, cpu_wdata=0xDEAD_BEEF, cpu_we=1 -> exactly one cycle with io_we=1, io_addr=0x0C, io_dout=0xDEADBEEF; cpu_ack 2 cycles after the request is sampled.
- IO read: addr 0xFFFF_FF14, io_din model returns 0x0000_1234 -> exactly one io_rd pulse; cpu_rdata=0x1234 in the ack cycle and held afterwards.
- CPU holds cpu_req through the ack cycle and drops it the next cycle -> only one io_rd pulse. If instead it keeps cpu_req high, a second transaction starts in the cycle after ACK.
- Memory write 0x0000_0010 <= 0xA5A5_0001, then read back -> mem_we with mem_addr=4; read has mem_re, then cpu_rdata=0xA5A50001 with ack 3 cycles after the request; no io_* strobe at any point.
- Misaligned read at 0x0000_0006, then misaligned write at 0xFFFF_FF01:
  - both ack after 1 cycle with no strobes;
  - first access returns cpu_rdata=0;
  - err=1 and err_addr=0x0000_0006 after both.
- Assert rstn low during IOR -> all strobes and cpu_ack 0 immediately; after release, state is IDLE and no stale ack appears.

Source files
------------

// File: rtl/mmio_bridge.sv
// CPU data-port bridge: decodes each access into a data-memory or PDU IO bus transaction.
// Every bus-side output is registered, and each access produces exactly one strobe.
module mmio_bridge #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00,
  parameter int unsigned MEM_AW  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        io_addr,
  output logic [31:0]       io_dout,
  output logic              io_we,
  output logic              io_rd,
  input  logic [31:0]       io_din,
  output logic              err,
  output logic [31:0]       err_addr
);

  typedef enum logic [2:0] {StIdle, StIow, StIor, StMwr, StMrd, StMcap, StAck} state_e;

  state_e             state_q, state_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_re_q, mem_re_d;
  logic [7:0]         io_addr_q, io_addr_d;
  logic [31:0]        io_dout_q, io_dout_d;
  logic               io_we_q, io_we_d;
  logic               io_rd_q, io_rd_d;
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic               is_io;

  assign is_io = (cpu_addr[31:8] == IO_BASE[31:8]);

  always_comb begin
    state_d     = state_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    io_addr_d   = io_addr_q;
    io_dout_d   = io_dout_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (is_io) begin
            io_addr_d = cpu_addr[7:0];
            io_dout_d = cpu_wdata;
          end else begin
            mem_addr_d  = cpu_addr[MEM_AW+1:2];
            mem_wdata_d = cpu_wdata;
          end
          if (cpu_addr[1:0] != 2'b00) begin
            state_d     = StAck;
            cpu_rdata_d = '0;
            // Only the first misaligned address is kept.
            if (!err_q) begin
              err_d      = 1'b1;
              err_addr_d = cpu_addr;
            end
          end else if (is_io) begin
            state_d = cpu_we ? StIow : StIor;
          end else begin
            state_d = cpu_we ? StMwr : StMrd;
          end
        end
      end
      StIow, StMwr: state_d = StAck;
      StIor: begin
        cpu_rdata_d = io_din;
        state_d     = StAck;
      end
      StMrd:  state_d = StMcap;
      StMcap: begin
        cpu_rdata_d = mem_rdata;
        state_d     = StAck;
      end
      // Request is ignored here so a held cpu_req is not re-issued in the same cycle.
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes and ack are registered decodes of the state being entered.
    cpu_ack_d = (state_d == StAck);
    io_we_d   = (state_d == StIow);
    io_rd_d   = (state_d == StIor);
    mem_we_d  = (state_d == StMwr);
    mem_re_d  = (state_d == StMrd);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      io_addr_q   <= '0;
      io_dout_q   <= '0;
      io_we_q     <= 1'b0;
      io_rd_q     <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      io_addr_q   <= io_addr_d;
      io_dout_q   <= io_dout_d;
      io_we_q     <= io_we_d;
      io_rd_q     <= io_rd_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign io_addr   = io_addr_q;
  assign io_dout   = io_dout_q;
  assign io_we     = io_we_q;
  assign io_rd     = io_rd_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed testbench for mmio_bridge: a small memory model, a combinational IO model and
// strobe monitors sampled on the falling edge.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [7:0]  io_addr;
  logic [31:0] io_dout, io_din;
  logic        io_we, io_rd;
  logic        err;
  logic [31:0] err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe monitors
  int          cnt_io_we = 0, cnt_io_rd = 0, cnt_mem_we = 0, cnt_mem_re = 0, cnt_excl = 0;
  logic [7:0]  mon_io_addr;
  logic [31:0] mon_io_dout;
  logic [7:0]  mon_mem_addr;
  logic [31:0] mon_mem_wdata;

  logic [31:0] mem_model [256];

  always #5 clk = ~clk;

  mmio_bridge #(.IO_BASE(32'hFFFF_FF00), .MEM_AW(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_we     (io_we),
    .io_rd     (io_rd),
    .io_din    (io_din),
    .err       (err),
    .err_addr  (err_addr)
  );

  assign io_din = (io_addr == 8'h14) ? 32'h0000_1234 : {24'hC0FFEE, io_addr};

  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (io_we) begin cnt_io_we++; mon_io_addr = io_addr; mon_io_dout = io_dout; end
      if (io_rd) begin cnt_io_rd++; mon_io_addr = io_addr; end
      if (mem_we) begin cnt_mem_we++; mon_mem_addr = mem_addr; mon_mem_wdata = mem_wdata; end
      if (mem_re) begin cnt_mem_re++; mon_mem_addr = mem_addr; end
      if ((32'(io_we) + 32'(io_rd) + 32'(mem_we) + 32'(mem_re)) > 1) cnt_excl++;
    end
  end

  // Drives one request at a falling edge; lat = falling edges until cpu_ack is seen (0 = timeout).
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic hold, output int lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_ack) begin lat = i; break; end
    end
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #22;
    chk("reset_strobes", {31'b0, cpu_ack | mem_we | mem_re | io_we | io_rd | err}, 32'h0);
    chk("reset_cpu_rdata", cpu_rdata, 32'h0);
    chk("reset_addrs", {16'h0, mem_addr, io_addr}, 32'h0);
    chk("reset_err_addr", err_addr, 32'h0);
    @(negedge clk); #2 rstn = 1'b1;
  endtask

  task automatic test_io_write;
    int lat, b_we, b_other;
    b_we = cnt_io_we; b_other = cnt_io_rd + cnt_mem_we + cnt_mem_re;
    access(1'b1, 32'hFFFF_FF0C, 32'hDEAD_BEEF, 1'b0, lat);
    chk("iow_latency", lat, 2);
    chk("iow_pulses", cnt_io_we - b_we, 1);
    chk("iow_io_addr", {24'h0, mon_io_addr}, 32'h0C);
    chk("iow_io_dout", mon_io_dout, 32'hDEAD_BEEF);
    chk("iow_other_strobes", cnt_io_rd + cnt_mem_we + cnt_mem_re - b_other, 0);
  endtask

  task automatic test_io_read;
    int lat, b_rd;
    b_rd = cnt_io_rd;
    access(1'b0, 32'hFFFF_FF14, 32'h0, 1'b0, lat);
    chk("ior_latency", lat, 2);
    chk("ior_ack_rdata", cpu_rdata, 32'h0000_1234);
    repeat (3) @(negedge clk);
    chk("ior_pulses", cnt_io_rd - b_rd, 1);
    chk("ior_rdata_held", cpu_rdata, 32'h0000_1234);
  endtask

  task automatic test_back_to_back;
    int lat, b_rd, gap;
    // Held through ACK, dropped in the following IDLE cycle: one access only.
    b_rd = cnt_io_rd;
    access(1'b0, 32'hFFFF_FF14, 32'h0, 1'b1, lat);
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_one_pulse", cnt_io_rd - b_rd, 1);
    chk("hold_no_ack", {31'b0, cpu_ack}, 32'h0);
    // Kept high: a second access starts after ACK, second ack 3 cycles after the first.
    b_rd = cnt_io_rd;
    access(1'b0, 32'hFFFF_FF14, 32'h0, 1'b1, lat);
    gap = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (cpu_ack) begin gap = i; break; end
    end
    cpu_req = 1'b0;
    chk("held_second_ack_gap", gap, 3);
    repeat (2) @(negedge clk);
    chk("held_two_pulses", cnt_io_rd - b_rd, 2);
  endtask

  task automatic test_memory;
    int lat, b_we, b_re, b_io;
    b_we = cnt_mem_we; b_re = cnt_mem_re; b_io = cnt_io_we + cnt_io_rd;
    access(1'b1, 32'h0000_0010, 32'hA5A5_0001, 1'b0, lat);
    chk("mwr_latency", lat, 2);
    chk("mwr_pulses", cnt_mem_we - b_we, 1);
    chk("mwr_addr", {24'h0, mon_mem_addr}, 32'h4);
    chk("mwr_wdata", mon_mem_wdata, 32'hA5A5_0001);
    chk("mwr_rdata_unchanged", cpu_rdata, 32'h0000_1234);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, lat);
    chk("mrd_latency", lat, 3);
    chk("mrd_pulses", cnt_mem_re - b_re, 1);
    chk("mrd_addr", {24'h0, mon_mem_addr}, 32'h4);
    chk("mrd_rdata", cpu_rdata, 32'hA5A5_0001);
    chk("mem_no_io_strobes", cnt_io_we + cnt_io_rd - b_io, 0);
  endtask

  task automatic test_boundary;
    int lat, b_iow;
    access(1'b1, 32'hFFFF_FEFC, 32'h0000_0011, 1'b0, lat);
    chk("bnd_fefc_mem_addr", {24'h0, mon_mem_addr}, 32'hBF);
    b_iow = cnt_io_we;
    access(1'b1, 32'hFFFF_FF00, 32'h0000_0022, 1'b0, lat);
    chk("bnd_ff00_is_io", cnt_io_we - b_iow, 1);
    chk("bnd_ff00_io_addr", {24'h0, mon_io_addr}, 32'h00);
    access(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, lat);
    chk("bnd_fffc_io_addr", {24'h0, mon_io_addr}, 32'hFC);
    chk("bnd_fffc_rdata", cpu_rdata, 32'hC0FF_EEFC);
    // Word 0x104 wraps onto word 0x04.
    access(1'b1, 32'h0000_0410, 32'h0000_0077, 1'b0, lat);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, lat);
    chk("wrap_rdata", cpu_rdata, 32'h0000_0077);
  endtask

  task automatic test_misaligned;
    int lat, b_all;
    b_all = cnt_io_we + cnt_io_rd + cnt_mem_we + cnt_mem_re;
    access(1'b0, 32'h0000_0006, 32'h0, 1'b0, lat);
    chk("mis_rd_latency", lat, 1);
    chk("mis_rd_rdata", cpu_rdata, 32'h0);
    chk("mis_rd_err", {31'b0, err}, 32'h1);
    access(1'b1, 32'hFFFF_FF01, 32'h1234_5678, 1'b0, lat);
    chk("mis_wr_latency", lat, 1);
    repeat (2) @(negedge clk);
    chk("mis_no_strobes", cnt_io_we + cnt_io_rd + cnt_mem_we + cnt_mem_re - b_all, 0);
    chk("mis_err_sticky", {31'b0, err}, 32'h1);
    chk("mis_err_addr_first", err_addr, 32'h0000_0006);
  endtask

  task automatic test_reset_mid;
    int lat, b_all;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FF14;
    @(negedge clk);
    chk("mid_in_ior", {31'b0, io_rd}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_outputs_cleared", {31'b0, cpu_ack | io_rd | io_we | mem_we | mem_re}, 32'h0);
    chk("mid_err_cleared", {31'b0, err}, 32'h0);
    cpu_req = 1'b0;
    @(negedge clk); #3 rstn = 1'b1;
    b_all = cnt_io_we + cnt_io_rd + cnt_mem_we + cnt_mem_re;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ack) lat++;
    end
    chk("mid_no_stale_ack", lat, 0);
    chk("mid_no_stale_strobe", cnt_io_we + cnt_io_rd + cnt_mem_we + cnt_mem_re - b_all, 0);
    access(1'b1, 32'hFFFF_FF08, 32'h0000_0055, 1'b0, lat);
    chk("mid_recover_latency", lat, 2);
  endtask

  initial begin
    test_reset();
    test_io_write();
    test_io_read();
    test_back_to_back();
    test_memory();
    test_boundary();
    test_misaligned();
    test_reset_mid();
    chk("strobe_exclusive", cnt_excl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
